// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB low-level NRZI transmitter.
`timescale 1ns/1ps
package usb_tx_pkg;

  // Default number of clk cycles in one USB bit time.
  localparam int DEFAULT_CLKS_PER_BIT = 8;

  // Consecutive transmitted ones that force a stuffed toggle.
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // Length of the SE0 part of end-of-packet, in bit times.
  localparam logic [1:0] EOP_SE0_BITS = 2'd2;

  // Transmitter sequencing states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } tx_state_t;

  // Line levels encoded as {d_plus, d_minus}.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_t;

  // Opposite differential level; SE0 never feeds this, J is the safe answer.
  function automatic line_t toggle_level(input line_t cur);
    return (cur == LINE_J) ? LINE_K : LINE_J;
  endfunction

  // NRZI encoding: a 0 toggles the line, a 1 holds it.
  function automatic line_t nrzi_level(input line_t cur, input logic data_bit);
    return data_bit ? cur : toggle_level(cur);
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 while enabled and strobes
// wrap on the last count, which marks the end of the current bit period.
`timescale 1ns/1ps
module usb_bit_timer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT  // must be >= 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic wrap
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count;

  // Free-running modulo counter, forced to zero while cleared.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + ONE;
    end
  end

  assign wrap = enable && !clear && (count == LAST);

endmodule

// File: rtl/usb_nrzi_tx.sv
// USB NRZI transmitter: byte stream in, bit-stuffed NRZI line out, with a
// one-byte holding register, seamless multi-byte packets and EOP generation.
`timescale 1ns/1ps
module usb_nrzi_tx
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT  // must be >= 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_err
);

  tx_state_t  state;
  line_t      line;
  logic [7:0] shifter;
  logic [2:0] bit_idx;
  logic [2:0] ones_cnt;
  logic [1:0] se0_cnt;
  logic       cur_last;

  logic [7:0] hold_data;
  logic       hold_last;
  logic       hold_full;
  logic       last_lock;  // a tx_last byte was taken; refuse more until EOP_J

  logic       wrap;
  logic       accept;
  logic       stuff_now;
  logic       byte_end;
  logic       load_hold;
  logic       enter_eop_j;
  logic       next_bit;

  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .enable (state != S_IDLE),
    .clear  (state == S_IDLE),
    .wrap   (wrap)
  );

  assign tx_ready = !hold_full && !last_lock;
  assign accept   = tx_valid && tx_ready;
  assign d_plus   = line[1];
  assign d_minus  = line[0];

  // Decode what happens at this clock: stuffing, byte completion, reload.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch forms.
    stuff_now   = 1'b0;
    byte_end    = 1'b0;
    load_hold   = 1'b0;
    enter_eop_j = 1'b0;
    next_bit    = shifter[bit_idx + 3'd1];
    case (state)
      S_IDLE:    load_hold = hold_full;
      S_DATA: begin
        if (wrap) begin
          if (ones_cnt == STUFF_LIMIT) stuff_now = 1'b1;
          else                         byte_end  = (bit_idx == 3'd7);
        end
      end
      S_STUFF:   byte_end = wrap && (bit_idx == 3'd7);
      S_EOP_SE0: enter_eop_j = wrap && (se0_cnt == EOP_SE0_BITS - 2'd1);
      default:   ;
    endcase
    if (byte_end) load_hold = hold_full;
    if (load_hold) next_bit = hold_data[0];
  end

  // Holding register: filled on handshake, emptied when the shifter takes it.
  // Full and empty events are exclusive, so byte order is always preserved.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      last_lock <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end else if (load_hold) begin
        hold_full <= 1'b0;
      end
      // A last byte still waiting in the holding register keeps the lock.
      if (accept && tx_last)           last_lock <= 1'b1;
      else if (enter_eop_j && !hold_full) last_lock <= 1'b0;
    end
  end

  // Transmit sequencer with registered line level, busy and error outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      line     <= LINE_J;
      shifter  <= '0;
      bit_idx  <= '0;
      ones_cnt <= '0;
      se0_cnt  <= '0;
      cur_last <= 1'b0;
      tx_busy  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      tx_err <= 1'b0;
      case (state)
        S_IDLE: begin
          line     <= LINE_J;
          ones_cnt <= '0;
          bit_idx  <= '0;
          if (load_hold) begin
            // First bit goes out on the very first DATA clock, referenced to J.
            shifter  <= hold_data;
            cur_last <= hold_last;
            line     <= nrzi_level(LINE_J, next_bit);
            ones_cnt <= next_bit ? 3'd1 : 3'd0;
            state    <= S_DATA;
            tx_busy  <= 1'b1;
          end
        end

        S_DATA, S_STUFF: begin
          if (stuff_now) begin
            line     <= toggle_level(line);
            ones_cnt <= '0;
            state    <= S_STUFF;
          end else if (byte_end && !load_hold) begin
            // Out of data: clean end if marked last, otherwise an underrun.
            line     <= LINE_SE0;
            ones_cnt <= '0;
            se0_cnt  <= '0;
            tx_err   <= !cur_last;
            state    <= S_EOP_SE0;
          end else if (wrap) begin
            if (load_hold) begin
              shifter  <= hold_data;
              cur_last <= hold_last;
              bit_idx  <= '0;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
            end
            line     <= nrzi_level(line, next_bit);
            ones_cnt <= next_bit ? ones_cnt + 3'd1 : 3'd0;
            state    <= S_DATA;
          end
        end

        S_EOP_SE0: begin
          if (enter_eop_j) begin
            line  <= LINE_J;
            state <= S_EOP_J;
          end else if (wrap) begin
            se0_cnt <= se0_cnt + 2'd1;
          end
        end

        S_EOP_J: begin
          if (wrap) begin
            state   <= S_IDLE;
            tx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          line    <= LINE_J;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
